pc_ras_unit: RTL and testbench
==============================

Name: pc_ras_unit

Overview:
Parametrised next-generation fetch program counter with its next-PC logic. It supports four PC sources (sequential, JR, J/JAL, branch) and a configurable return-address stack (RAS) that predicts JR $31 targets. It also flags misaligned register targets. It sits at the head of the fetch stage, drives the instruction memory address, and supplies PC+4 for link writes.

Parameters:
WIDTH, 32, PC/address width in bits; must be >= 32.
PC_INIT, 0, PC value loaded on reset; must be word-aligned.
RAS_DEPTH, 4, number of RAS entries; power of two, >= 2.

Ports:
CLK  in  1  system clock, all state updates on rising edge.
RST  in  1  synchronous active-high reset.
pc_en  in  1  advance enable; low = hold all state.
pc_src  in  2  next-PC select: SEQ=0, JR=1, JUMP=2, BRANCH=3.
rdat1  in  WIDTH  register $rs value, used as JR target.
immediate26  in  26  J/JAL instruction index.
immediate  in  WIDTH  sign-extended branch offset, in words.
ras_push  in  1  current instruction is JAL; push pc_plus_4.
ras_pop  in  1  current JR uses $31; pop RAS and use it as the predicted target.
imemaddr  out  WIDTH  current PC.
pc_plus_4  out  WIDTH  PC+4 (combinational).
ras_empty  out  1  RAS count == 0.
ras_hit  out  1  JR target was taken from the RAS this cycle (combinational).
ras_mispredict  out  1  ras_hit and RAS top != {rdat1[WIDTH-1:2],2'b00} (combinational).
misalign  out  1  pc_src==JR, target taken from rdat1, and rdat1[1:0] != 0 (combinational).

Behaviour:
- Reset (RST high at a clock edge): PC <= PC_INIT, RAS count <= 0, top pointer <= 0. RAS entry contents are don't-care. Reset overrides pc_en, push and pop in the same cycle.
- Outputs after reset: imemaddr=PC_INIT, pc_plus_4=PC_INIT+4, ras_empty=1. ras_hit, ras_mispredict and misalign are 0 unless the inputs assert them.
- Arithmetic is modulo 2^WIDTH; wrap-around at the top of the address space is silent.
- Next-PC selection:
  - SEQ: PC+4.
  - JR with ras_pop and RAS not empty: RAS top (ras_hit=1).
  - JR otherwise: {rdat1[WIDTH-1:2],2'b00}. misalign is asserted if rdat1[1:0]!=0.
  - JUMP: {pc_plus_4[WIDTH-1:28], immediate26, 2'b00}.
  - BRANCH: pc_plus_4 + (immediate << 2). This is the taken target; the decoder selects SEQ when the branch is not taken.
- Update latency: 1 cycle. PC <= next-PC on a rising edge with pc_en=1. With pc_en=0, PC, the RAS and its pointers hold, and ras_push/ras_pop are ignored.
- RAS is a circular buffer of RAS_DEPTH entries, with the top pointer and a count saturating at RAS_DEPTH. All RAS updates are qualified by pc_en.
  - Push only: write pc_plus_4 at top+1, top <= top+1, count <= min(count+1, RAS_DEPTH). When full, the oldest entry is overwritten and count stays at RAS_DEPTH.
  - Pop only, not empty: top <= top-1, count <= count-1.
  - Pop on empty: no state change; the JR falls back to rdat1 and ras_hit=0.
  - Push and pop together: overwrite the top entry with pc_plus_4; pointer and count are unchanged. The popped (old) value is used as the target.
- ras_pop with pc_src != JR: pop is performed, and the next PC follows pc_src.
- ras_mispredict is informational only; redirecting the PC is the hazard unit's job.
- The RAS is read combinationally and written synchronously.

Decomposition:
- cpu_types_pkg gains the pc_src_t enum (SEQ, JR, JUMP, BRANCH) and the constant PC_INC = 4.
- Sub-module ras_stack(CLK, RST, push, pop, en, wdata, top, empty) holds the circular buffer, pointer and saturating count.
- pc_ras_unit holds the PC register, the next-PC mux and the flag logic.
- The pc_if interface gains ras_push, ras_pop, ras_hit, ras_mispredict and misalign.

Test Plan:
- Reset then 3 cycles SEQ with pc_en=1 -> imemaddr 0x0, 0x4, 0x8, 0xC. Then pc_en=0 for 2 cycles -> holds 0xC.
- PC=0x00400010, JUMP, immediate26=0x0000040 -> next PC 0x00000100. Then BRANCH with immediate=-2 (0xFFFFFFFE) at PC=0x100 -> next PC 0x0FC.
- JAL at PC=0x20 (JUMP + ras_push) -> RAS top=0x24, ras_empty=0. Later JR+ras_pop with rdat1=0x24 -> PC=0x24, ras_hit=1, ras_mispredict=0, ras_empty=1.
- RAS_DEPTH=4: push 0x104, 0x204, 0x304, 0x404, 0x504, then pop 5 times with JR -> targets 0x504, 0x404, 0x304, 0x204. The 5th pop uses rdat1 with ras_hit=0.
- JR+ras_pop with RAS top=0x40 and rdat1=0x80 -> PC=0x40, ras_mispredict=1. JR with ras_pop=0 and rdat1=0x83 -> PC=0x80, misalign=1.
- Push and pop together with top=0x40 at PC=0x10 -> target 0x40, top becomes 0x14, count unchanged. Assert RST mid-sequence -> PC=PC_INIT, ras_empty=1 on the next cycle.

Source files
------------

// File: rtl/pc_ras_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_ras_unit_pkg
//  Purpose  : Shared types and constants for the fetch PC / return-address
//             stack block. Defines the next-PC source encoding and the PC
//             increment used for sequential fetch and link addresses.
//  Revision : 1.0  - initial release
// ============================================================================
package pc_ras_unit_pkg;

    // Next-PC source select. The encoding is visible on the decoder-facing
    // pc_src bus, so the values are fixed.
    typedef enum logic [1:0] {
        SEQ    = 2'd0,
        JR     = 2'd1,
        JUMP   = 2'd2,
        BRANCH = 2'd3
    } pc_src_t;

    // Byte distance between consecutive instruction words.
    localparam int unsigned PC_INC = 4;

endpackage : pc_ras_unit_pkg
`default_nettype wire

// File: rtl/pc_ras_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_ras_unit_if
//  Purpose  : Bundle between the decode/control side and the fetch PC unit.
//  Ports    : master - decode/control side; drives the PC select, operands
//                      and RAS push/pop requests, observes PC and flags.
//             slave  - PC unit; consumes the requests, drives imemaddr,
//                      pc_plus_4 and the RAS / alignment status flags.
//  Revision : 1.0  - initial release
// ============================================================================
interface pc_ras_unit_if
    import pc_ras_unit_pkg::*;
#(
    parameter int WIDTH = 32
);
    // Control side -> PC unit
    logic              pc_en;
    pc_src_t           pc_src;
    logic [WIDTH-1:0]  rdat1;
    logic [25:0]       immediate26;
    logic [WIDTH-1:0]  immediate;
    logic              ras_push;
    logic              ras_pop;

    // PC unit -> control side / instruction memory
    logic [WIDTH-1:0]  imemaddr;
    logic [WIDTH-1:0]  pc_plus_4;
    logic              ras_empty;
    logic              ras_hit;
    logic              ras_mispredict;
    logic              misalign;

    modport master (
        output pc_en, pc_src, rdat1, immediate26, immediate, ras_push, ras_pop,
        input  imemaddr, pc_plus_4, ras_empty, ras_hit, ras_mispredict, misalign
    );

    modport slave (
        input  pc_en, pc_src, rdat1, immediate26, immediate, ras_push, ras_pop,
        output imemaddr, pc_plus_4, ras_empty, ras_hit, ras_mispredict, misalign
    );

endinterface : pc_ras_unit_if
`default_nettype wire

// File: rtl/pc_ras_unit_ras_stack.sv
`default_nettype none
// ============================================================================
//  Module   : pc_ras_unit_ras_stack
//  Purpose  : Circular return-address stack with a saturating occupancy
//             count. On overflow the oldest entry is silently overwritten.
//             Read is combinational (top of stack), write is synchronous.
//  Ports    : CLK   - clock
//             RST   - synchronous active-high reset (pointer and count only)
//             push  - write wdata as new top
//             pop   - discard current top (ignored when empty)
//             en    - qualifies push and pop
//             wdata - value to push
//             top   - current top entry (combinational)
//             empty - occupancy is zero
//  Revision : 1.0  - initial release
// ============================================================================
module pc_ras_unit_ras_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  wire logic              CLK,
    input  wire logic              RST,
    input  wire logic              push,
    input  wire logic              pop,
    input  wire logic              en,
    input  wire logic [WIDTH-1:0]  wdata,
    output logic      [WIDTH-1:0]  top,
    output logic                   empty
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_ptr_w-1:0]  r_top;
    logic [c_cnt_w-1:0]  r_count;

    logic                w_empty;
    logic                w_full;
    logic                w_do_push;
    logic                w_do_pop;
    logic [c_ptr_w-1:0]  w_wptr;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_cnt_w'(DEPTH));
    assign w_do_push = en & push;
    // Popping an empty stack is a no-op, so a push+pop on empty acts as a
    // plain push.
    assign w_do_pop  = en & pop & ~w_empty;

    // Push+pop replaces the current top in place; a plain push goes one slot
    // above it. The pointer wraps naturally because DEPTH is a power of two.
    assign w_wptr    = w_do_pop ? r_top : r_top + c_ptr_w'(1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (w_do_push && !w_do_pop) begin
            r_top <= r_top + c_ptr_w'(1);
            if (!w_full) begin
                r_count <= r_count + c_cnt_w'(1);
            end
        end else if (w_do_pop && !w_do_push) begin
            r_top   <= r_top - c_ptr_w'(1);
            r_count <= r_count - c_cnt_w'(1);
        end
    end

    // Entry storage carries no reset; contents are only meaningful while
    // covered by the occupancy count.
    always_ff @(posedge CLK) begin
        if (!RST && w_do_push) begin
            r_mem[w_wptr] <= wdata;
        end
    end

    assign top   = r_mem[r_top];
    assign empty = w_empty;

endmodule : pc_ras_unit_ras_stack
`default_nettype wire

// File: rtl/pc_ras_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_ras_unit
//  Purpose  : Fetch program counter with next-PC selection (sequential,
//             register jump, J/JAL, taken branch) and a return-address stack
//             that predicts JR $31 targets. Flags RAS hits, RAS mispredicts
//             and misaligned register-jump targets.
//  Ports    : CLK  - clock
//             RST  - synchronous active-high reset
//             pcif - pc_ras_unit_if.slave bundle:
//                    in : pc_en, pc_src, rdat1, immediate26, immediate,
//                         ras_push, ras_pop
//                    out: imemaddr, pc_plus_4, ras_empty, ras_hit,
//                         ras_mispredict, misalign
//  Revision : 1.0  - initial release
// ============================================================================
module pc_ras_unit
    import pc_ras_unit_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] PC_INIT   = {WIDTH{1'b0}},
    parameter int               RAS_DEPTH = 4
) (
    input  wire logic          CLK,
    input  wire logic          RST,
    pc_ras_unit_if.slave       pcif
);

    logic [WIDTH-1:0]  r_pc;

    logic [WIDTH-1:0]  w_pc_plus_4;
    logic [WIDTH-1:0]  w_next_pc;
    logic [WIDTH-1:0]  w_ras_top;
    logic              w_ras_empty;
    logic              w_ras_hit;
    logic [WIDTH-1:0]  w_jr_target;
    logic [WIDTH-1:0]  w_jump_target;
    logic [WIDTH-1:0]  w_branch_target;

    // ------------------------------------------------------------------
    // Return-address stack. Pop is honoured for any pc_src so that the
    // stack stays in step with the call depth even when the decoder does
    // not use the predicted target.
    // ------------------------------------------------------------------
    pc_ras_unit_ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .CLK   (CLK),
        .RST   (RST),
        .push  (pcif.ras_push),
        .pop   (pcif.ras_pop),
        .en    (pcif.pc_en),
        .wdata (w_pc_plus_4),
        .top   (w_ras_top),
        .empty (w_ras_empty)
    );

    // ------------------------------------------------------------------
    // Candidate targets
    // ------------------------------------------------------------------
    assign w_pc_plus_4     = r_pc + WIDTH'(PC_INC);
    assign w_jr_target     = {pcif.rdat1[WIDTH-1:2], 2'b00};
    assign w_jump_target   = {w_pc_plus_4[WIDTH-1:28], pcif.immediate26, 2'b00};
    // Branch offset is in words; the low two bits of the shifted value are
    // zero and the top two bits fall off (modulo arithmetic).
    assign w_branch_target = w_pc_plus_4 + {pcif.immediate[WIDTH-3:0], 2'b00};

    assign w_ras_hit = (pcif.pc_src == JR) & pcif.ras_pop & ~w_ras_empty;

    always_comb begin
        w_next_pc = w_pc_plus_4;
        case (pcif.pc_src)
            SEQ:     w_next_pc = w_pc_plus_4;
            JR:      w_next_pc = w_ras_hit ? w_ras_top : w_jr_target;
            JUMP:    w_next_pc = w_jump_target;
            BRANCH:  w_next_pc = w_branch_target;
            default: w_next_pc = w_pc_plus_4;
        endcase
    end

    // ------------------------------------------------------------------
    // PC register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc <= PC_INIT;
        end else if (pcif.pc_en) begin
            r_pc <= w_next_pc;
        end
    end

    // ------------------------------------------------------------------
    // Outputs and status flags
    // ------------------------------------------------------------------
    assign pcif.imemaddr       = r_pc;
    assign pcif.pc_plus_4      = w_pc_plus_4;
    assign pcif.ras_empty      = w_ras_empty;
    assign pcif.ras_hit        = w_ras_hit;
    // Compared against the aligned register value, so a predicted return to
    // the word holding a misaligned rdat1 is not counted as a mispredict.
    assign pcif.ras_mispredict = w_ras_hit & (w_ras_top != w_jr_target);
    // Only meaningful when the register value is actually used as target.
    assign pcif.misalign       = (pcif.pc_src == JR) & ~w_ras_hit
                                 & (pcif.rdat1[1:0] != 2'b00);

endmodule : pc_ras_unit
`default_nettype wire

// File: tb/tb_pc_ras_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_ras_unit
//  Purpose  : Self-checking bench for pc_ras_unit: directed scenarios plus
//             randomized traffic compared against a queue-based model.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_pc_ras_unit;
    import pc_ras_unit_pkg::*;

    localparam int          c_w     = 32;
    localparam int          c_depth = 4;
    localparam logic [31:0] c_init  = 32'h0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        empty;
        logic        hit;
        logic        mispred;
        logic        misalign;
    } exp_t;

    logic CLK;
    logic RST;

    pc_ras_unit_if #(.WIDTH(c_w)) pif ();

    pc_ras_unit #(
        .WIDTH     (c_w),
        .PC_INIT   (c_init),
        .RAS_DEPTH (c_depth)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .pcif (pif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural PC and a stack whose back is the top.
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    exp_t        exp_q[$];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compares the DUT outputs mid-cycle against the oldest
    // expectation issued by the driver.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp("imemaddr",       pif.imemaddr,              e.pc);
            cmp("pc_plus_4",      pif.pc_plus_4,             e.pc4);
            cmp("ras_empty",      {31'b0, pif.ras_empty},      {31'b0, e.empty});
            cmp("ras_hit",        {31'b0, pif.ras_hit},        {31'b0, e.hit});
            cmp("ras_mispredict", {31'b0, pif.ras_mispredict}, {31'b0, e.mispred});
            cmp("misalign",       {31'b0, pif.misalign},       {31'b0, e.misalign});
        end
    end

    task automatic model_reset();
        m_pc = c_init;
        m_ras.delete();
    endtask

    // Drive one cycle of inputs, issue the expectation, advance the model.
    task automatic step(input bit en, input logic [1:0] src, input logic [31:0] r1,
                        input logic [25:0] i26, input logic [31:0] imm,
                        input bit push, input bit pop);
        exp_t        e;
        logic [31:0] pc4, nxt, top, aligned;
        bit          hit;
        pif.pc_en       = en;
        pif.pc_src      = pc_src_t'(src);
        pif.rdat1       = r1;
        pif.immediate26 = i26;
        pif.immediate   = imm;
        pif.ras_push    = push;
        pif.ras_pop     = pop;

        pc4     = m_pc + 32'd4;
        aligned = r1 & ~32'h3;
        top     = (m_ras.size() > 0) ? m_ras[$] : 32'h0;
        hit     = (src == 2'd1) && pop && (m_ras.size() > 0);
        case (src)
            2'd0:    nxt = pc4;
            2'd1:    nxt = hit ? top : aligned;
            2'd2:    nxt = (pc4 & 32'hF000_0000) | (32'(i26) * 32'd4);
            default: nxt = pc4 + imm * 32'd4;
        endcase
        e.pc       = m_pc;
        e.pc4      = pc4;
        e.empty    = (m_ras.size() == 0);
        e.hit      = hit;
        e.mispred  = hit && (top != aligned);
        e.misalign = (src == 2'd1) && !hit && (r1 % 4 != 0);
        exp_q.push_back(e);

        @(posedge CLK);
        if (en) begin
            m_pc = nxt;
            if (pop && m_ras.size() > 0) void'(m_ras.pop_back());
            if (push) begin
                m_ras.push_back(pc4);
                if (m_ras.size() > c_depth) void'(m_ras.pop_front());
            end
        end
        #1;
    endtask

    // Reset while requesting a push, a pop and a PC advance: reset must win.
    task automatic do_reset();
        RST             = 1'b1;
        pif.pc_en       = 1'b1;
        pif.pc_src      = JR;
        pif.rdat1       = 32'h1234_5678;
        pif.immediate26 = '0;
        pif.immediate   = '0;
        pif.ras_push    = 1'b1;
        pif.ras_pop     = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
    endtask

    initial begin
        RST = 1'b1;
        do_reset();

        // Sequential fetch and hold
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        cmp("seq_pc_0xC", pif.imemaddr, 32'hC);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 1, 32'h40, 0, 0, 0, 1);
        cmp("hold_pc", pif.imemaddr, 32'hC);
        cmp("hold_ras_empty", {31'b0, pif.ras_empty}, 32'd1);

        // Jump and negative branch
        step(1, 1, 32'h0040_0010, 0, 0, 0, 0);
        step(1, 2, 0, 26'h40, 0, 0, 0);
        cmp("jump_pc", pif.imemaddr, 32'h100);
        step(1, 3, 0, 0, 32'hFFFF_FFFE, 0, 0);
        cmp("branch_neg_pc", pif.imemaddr, 32'hFC);

        // JAL then JR $31 with correct prediction
        step(1, 1, 32'h20, 0, 0, 0, 0);
        step(1, 2, 0, 26'h30, 0, 1, 0);
        cmp("jal_ras_not_empty", {31'b0, pif.ras_empty}, 32'd0);
        step(1, 1, 32'h24, 0, 0, 0, 1);
        cmp("jr_ras_pc", pif.imemaddr, 32'h24);
        cmp("jr_ras_empty_after", {31'b0, pif.ras_empty}, 32'd1);

        // Overflow: five pushes into a depth-4 stack, then five pops
        step(1, 1, 32'h100, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 32'h200 + 32'h100 * i, 0, 0, 1, 0);
        end
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 32'h700, 0, 0, 0, 1);
            cmp("overflow_pop_pc", pif.imemaddr, 32'h504 - 32'h100 * i);
        end
        step(1, 1, 32'h700, 0, 0, 0, 1);
        cmp("pop_empty_fallback_pc", pif.imemaddr, 32'h700);

        // Mispredict then misaligned register jump
        step(1, 1, 32'h3C, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0);
        step(1, 1, 32'h80, 0, 0, 0, 1);
        cmp("mispredict_pc", pif.imemaddr, 32'h40);
        step(1, 1, 32'h83, 0, 0, 0, 0);
        cmp("misalign_pc", pif.imemaddr, 32'h80);

        // Simultaneous push and pop replaces the top
        step(1, 1, 32'h3C, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0);
        step(1, 1, 32'h10, 0, 0, 0, 0);
        step(1, 1, 32'h40, 0, 0, 1, 1);
        cmp("pushpop_pc", pif.imemaddr, 32'h40);
        cmp("pushpop_not_empty", {31'b0, pif.ras_empty}, 32'd0);
        step(1, 1, 32'h14, 0, 0, 0, 1);
        cmp("pushpop_new_top_pc", pif.imemaddr, 32'h14);
        cmp("pushpop_count_kept", {31'b0, pif.ras_empty}, 32'd1);

        // Mid-sequence reset
        step(1, 0, 0, 0, 0, 1, 0);
        do_reset();
        cmp("reset_pc", pif.imemaddr, c_init);
        cmp("reset_ras_empty", {31'b0, pif.ras_empty}, 32'd1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] r1;
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                if (m_ras.size() > 0 && $urandom_range(0, 1) == 1) begin
                    r1 = m_ras[$] | 32'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : 0);
                end else begin
                    r1 = $urandom();
                end
                step($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), r1,
                     26'($urandom()), 32'($urandom_range(0, 64)) - 32'd32,
                     $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            end
        end

        repeat (2) @(posedge CLK);
        cmp("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pc_ras_unit
`default_nettype wire
